// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: key code valid/ready handshake into the keypad emulator.
interface keypad_emulator_if;
   logic [3:0] key_in;
   logic       key_valid;
   logic       key_ready;
   modport master (output key_in, output key_valid, input key_ready);
   modport slave (input key_in, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 key matrix responder that presses queued key codes for a set number of full scans.
module keypad_emulator #(
   parameter int HOLD_SCANS   = 4,
   parameter int GAP_SCANS    = 2,
   parameter int BOUNCE_SCANS = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         SWR,
   output logic [3:0]         SWC,
   keypad_emulator_if.slave   key,
   output logic               busy,
   output logic               done,
   output logic [7:0]         press_count
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_SYNC = 2'd1;
   localparam logic [1:0] PRESS     = 2'd2;
   localparam logic [1:0] GAP       = 2'd3;
   logic [1:0] state;
   logic [3:0] key_q;
   logic [7:0] cnt;
   logic       boundary;
   logic       row_hit;
   logic       bounce_off;
   assign boundary      = SWR == 4'b0111;
   assign key.key_ready = state == IDLE;
   assign busy          = state != IDLE;
   // exact match against the one-low row pattern also rejects illegal strobes
   assign row_hit    = SWR == ~(4'b0001 << key_q[3:2]);
   assign bounce_off = (cnt < 8'(BOUNCE_SCANS)) && cnt[0];
   assign SWC        = (state == PRESS && row_hit && !bounce_off) ? ~(4'b0001 << key_q[1:0]) : 4'b1111;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         key_q       <= '0;
         cnt         <= '0;
         done        <= 1'b0;
         press_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (key.key_valid) begin
               key_q <= key.key_in;
               state <= WAIT_SYNC;
            end
            WAIT_SYNC: if (boundary) begin
               state <= PRESS;
               cnt   <= '0;
            end
            PRESS: if (boundary) begin
               state <= (cnt == 8'(HOLD_SCANS - 1)) ? GAP : PRESS;
               cnt   <= (cnt == 8'(HOLD_SCANS - 1)) ? 8'd0 : cnt + 8'd1;
            end
            default: if (boundary) begin
               if (cnt == 8'(GAP_SCANS - 1)) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  done        <= 1'b1;
                  press_count <= press_count + 8'd1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: two emulators (no bounce / 2 bounce scans) checked against a scan-counting model.
module tb_keypad_emulator;
   localparam int HOLD = 4;
   localparam int GAP  = 2;
   logic       clk = 0;
   logic       rst = 1;
   logic [3:0] swr = 4'b1110;
   logic [3:0] key_in = 0;
   logic       key_valid = 0;
   logic [3:0] swc0, swc1;
   logic       busy0, busy1, done0, done1;
   logic [7:0] pc0, pc1;
   int         checks = 0;
   int         failures = 0;
   logic [1:0] ri = 0;
   bit         rand_mode = 0;
   bit         swr_force = 0;
   logic [3:0] swr_forced = 4'b1100;
   bit         m_active = 0;
   bit         m_done = 0;
   int         m_nb = 0;
   int         m_key = 0;
   int         m_pc = 0;

   keypad_emulator_if kif0 ();
   keypad_emulator_if kif1 ();
   assign kif0.key_in = key_in;
   assign kif0.key_valid = key_valid;
   assign kif1.key_in = key_in;
   assign kif1.key_valid = key_valid;

   keypad_emulator #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .BOUNCE_SCANS(0)) dut0 (
      .clk(clk), .rst(rst), .SWR(swr), .SWC(swc0), .key(kif0.slave),
      .busy(busy0), .done(done0), .press_count(pc0));
   keypad_emulator #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .BOUNCE_SCANS(2)) dut1 (
      .clk(clk), .rst(rst), .SWR(swr), .SWC(swc1), .key(kif1.slave),
      .busy(busy1), .done(done1), .press_count(pc1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int zero_pos(input logic [3:0] v);
      int n = 0;
      int p = -1;
      for (int i = 0; i < 4; i++) if (!v[i]) begin n++; p = i; end
      return (n == 1) ? p : -1;
   endfunction

   // Model: count strobe boundaries since acceptance; scans 1..HOLD press, next GAP release.
   function automatic logic [3:0] exp_swc(input int bounce);
      int idx = m_nb - 1;
      bit pressing = m_active && m_nb >= 1 && m_nb <= HOLD;
      bit shown = (idx >= bounce) || (idx % 2 == 0);
      if (pressing && shown && zero_pos(swr) == m_key / 4) return 4'hF ^ 4'(1 << (m_key % 4));
      return 4'hF;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 0; m_done = 0; m_nb = 0; m_key = 0; m_pc = 0;
      end else begin
         m_done = 0;
         if (!m_active) begin
            if (key_valid) begin m_active = 1; m_key = int'(key_in); m_nb = 0; end
         end else if (swr == 4'b0111) begin
            m_nb++;
            if (m_nb == 1 + HOLD + GAP) begin m_active = 0; m_done = 1; m_pc = (m_pc + 1) % 256; end
         end
      end
   end

   always @(negedge clk) begin
      chk("swc0", swc0, exp_swc(0));
      chk("swc1", swc1, exp_swc(2));
      chk("busy", {busy0, busy1}, {2{m_active}});
      chk("ready", {kif0.key_ready, kif1.key_ready}, {2{!m_active}});
      chk("done", {done0, done1}, {2{m_done}});
      chk("press_count", {pc0, pc1}, {2{8'(m_pc)}});
   end

   always @(posedge clk) begin
      #1;
      if (swr_force) swr = swr_forced;
      else if (!rand_mode || $urandom_range(9) < 7) begin ri = ri + 2'd1; swr = ~(4'b0001 << ri); end
      else if ($urandom_range(1) == 0) swr = 4'($urandom);
   end

   task automatic run_press(input logic [3:0] k, input logic [3:0] e_swr, input logic [3:0] e_swc, input int e_pc);
      int nz0 = 0;
      int nz1 = 0;
      int dk = -1;
      bit seen = 0;
      @(posedge clk); #1; key_in = k; key_valid = 1;
      @(posedge clk); #1; key_valid = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (swc0 != 4'hF) begin
            nz0++;
            chk("press_swr", swr, e_swr);
            chk("press_swc", swc0, e_swc);
            dk = zero_pos(swr) * 4 + zero_pos(swc0);
         end
         if (swc1 != 4'hF) nz1++;
         if (done0) seen = 1;
      end
      chk("done_seen", seen, 1);
      chk("hold_cycles", nz0, HOLD);
      chk("bounce_cycles", nz1, HOLD - 1);
      chk("decoded_key", dk, k);
      chk("count_at_done", pc0, e_pc);
      chk("ready_at_done", kif0.key_ready, 1);
   endtask

   initial begin
      bit seen;
      bit any_done;
      repeat (6) @(negedge clk);
      chk("rst_swc", swc0, 4'hF);
      chk("rst_ready", kif0.key_ready, 1);
      chk("rst_busy", busy0, 0);
      chk("rst_count", pc0, 0);
      @(posedge clk); #1; rst = 0;
      run_press(4'd5, 4'b1101, 4'b1101, 1);
      run_press(4'd15, 4'b0111, 4'b0111, 2);
      run_press(4'd0, 4'b1110, 4'b1110, 3);
      run_press(4'd6, 4'b1101, 4'b1011, 4);
      // held key_valid: 3 then 12, the second taken in the done cycle
      @(posedge clk); #1; key_in = 4'd3; key_valid = 1;
      @(posedge clk); #1; key_in = 4'd12;
      @(negedge clk);
      chk("held_ready_low", kif0.key_ready, 0);
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin @(negedge clk); if (done0) seen = 1; end
      chk("held_done1", seen, 1);
      chk("held_ready_at_done", kif0.key_ready, 1);
      @(posedge clk); #1; key_valid = 0;
      @(negedge clk);
      chk("held_busy_again", busy0, 1);
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (swc0 != 4'hF) begin chk("key12_swr", swr, 4'b0111); chk("key12_swc", swc0, 4'b1110); end
         if (done0) seen = 1;
      end
      chk("held_done2", seen, 1);
      chk("held_count", pc0, 6);
      // illegal strobe and reset in the middle of a press
      @(posedge clk); #1; key_in = 4'd6; key_valid = 1;
      @(posedge clk); #1; key_valid = 0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); if (swc0 == 4'b1011) seen = 1; end
      chk("press6_seen", seen, 1);
      swr_force = 1;
      @(negedge clk);
      chk("illegal_swr", swr, 4'b1100);
      chk("illegal_swc", {swc0, swc1}, 8'hFF);
      chk("illegal_busy", busy0, 1);
      swr_force = 0;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); if (swc0 == 4'b1011) seen = 1; end
      chk("press6_again", seen, 1);
      #2 rst = 1;
      #1;
      chk("abort_swc", {swc0, swc1}, 8'hFF);
      chk("abort_busy", busy0, 0);
      chk("abort_count", pc0, 0);
      chk("abort_ready", kif0.key_ready, 1);
      @(posedge clk); #1; rst = 0;
      any_done = 0;
      repeat (40) begin @(negedge clk); if (done0 || done1) any_done = 1; end
      chk("abort_no_done", any_done, 0);
      rand_mode = 1;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         key_valid = $urandom_range(1);
         key_in = 4'($urandom);
         rst = ($urandom_range(799) == 0);
      end
      @(posedge clk); #1; rst = 0; key_valid = 0;
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
